// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared types for the CCE pending-counter block
package bp_me_pkg;

  localparam int bp_pending_width_gp    = 3;
  localparam int bp_pending_wg_width_gp = 16;

  // Captured saturation error; wg is wide enough for any way-group count in use
  typedef struct packed {
    logic                              ovf;
    logic [bp_pending_wg_width_gp-1:0] wg;
  } bp_pending_err_s;

endpackage

// File: rtl/bp_cce_pending_wg_hash.sv
// rtl/bp_cce_pending_wg_hash.sv - maps a physical address to a local way group
module bp_cce_pending_wg_hash
  import bp_me_pkg::*;
#(
  parameter int num_way_groups_p = 8,
  parameter int cce_way_groups_p = 8,
  parameter int num_cce_p        = 1,
  parameter int paddr_width_p    = 40,
  parameter int addr_offset_p    = 6,
  localparam int lg_wg_lp        = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
  localparam int lg_cce_wg_lp    = (cce_way_groups_p > 1) ? $clog2(cce_way_groups_p) : 1
) (
  input  logic [paddr_width_p-1:0] addr_i,
  input  logic                     bypass_hash_i,
  output logic [lg_wg_lp-1:0]      wg_o
);

  logic [lg_cce_wg_lp-1:0] field;
  logic [lg_cce_wg_lp-1:0] field_rev;
  logic [31:0]             hash_idx;
  logic                    unused_bits;

  assign field = addr_i[addr_offset_p+:lg_cce_wg_lp];

  always_comb begin
    field_rev = '0;
    for (int i = 0; i < lg_cce_wg_lp; i++) begin
      field_rev[i] = field[lg_cce_wg_lp-1-i];
    end
  end

  // Bank-hash index: consecutive system way groups stripe across the CCEs
  assign hash_idx = 32'(field_rev) / 32'(num_cce_p);

  assign wg_o        = bypass_hash_i ? addr_i[lg_wg_lp-1:0] : hash_idx[lg_wg_lp-1:0];
  assign unused_bits = ^{addr_i, hash_idx};

endmodule

// File: rtl/bp_cce_pending_counters.sv
// rtl/bp_cce_pending_counters.sv - per-way-group pending counters with forwarded reads
// Saturation and error capture enabled by BP_CCE_PENDING_SATURATE_EN; otherwise counters wrap.
module bp_cce_pending_counters
  import bp_me_pkg::*;
#(
  parameter int num_way_groups_p = 8,
  parameter int cce_way_groups_p = 8,
  parameter int num_cce_p        = 1,
  parameter int paddr_width_p    = 40,
  parameter int addr_offset_p    = 6,
  parameter int width_p          = bp_pending_width_gp,
  parameter int num_rd_ports_p   = 2,
  localparam int lg_wg_lp        = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  inc_v_i,
  input  logic [paddr_width_p-1:0]              inc_addr_i,
  input  logic                                  inc_bypass_hash_i,
  input  logic                                  dec_v_i,
  input  logic [paddr_width_p-1:0]              dec_addr_i,
  input  logic                                  dec_bypass_hash_i,
  input  logic                                  clr_v_i,
  input  logic [paddr_width_p-1:0]              clr_addr_i,
  input  logic                                  clr_bypass_hash_i,
  input  logic [num_rd_ports_p-1:0]             r_v_i,
  input  logic [num_rd_ports_p*paddr_width_p-1:0] r_addr_i,
  input  logic [num_rd_ports_p-1:0]             r_bypass_hash_i,
  output logic [num_rd_ports_p-1:0]             pending_o,
  output logic [num_rd_ports_p*width_p-1:0]     count_o,
  output logic                                  any_pending_o,
  output logic                                  err_o,
  output logic                                  err_ovf_o,
  output logic [lg_wg_lp-1:0]                   err_wg_o,
  input  logic                                  err_clr_i
);

`ifdef BP_CCE_PENDING_SATURATE_EN
  localparam bit sat_en_lp = 1'b1;
`else
  localparam bit sat_en_lp = 1'b0;
`endif

  logic [width_p-1:0]  cnt_r [num_way_groups_p];
  logic [width_p-1:0]  cnt_n [num_way_groups_p];
  logic [lg_wg_lp-1:0] inc_wg, dec_wg, clr_wg;
  logic [lg_wg_lp-1:0] r_wg [num_rd_ports_p];
  logic                err_ev, err_ev_ovf;
  logic [lg_wg_lp-1:0] err_ev_wg;

  bp_cce_pending_wg_hash #(
    .num_way_groups_p(num_way_groups_p), .cce_way_groups_p(cce_way_groups_p),
    .num_cce_p(num_cce_p), .paddr_width_p(paddr_width_p), .addr_offset_p(addr_offset_p)
  ) inc_hash (.addr_i(inc_addr_i), .bypass_hash_i(inc_bypass_hash_i), .wg_o(inc_wg));

  bp_cce_pending_wg_hash #(
    .num_way_groups_p(num_way_groups_p), .cce_way_groups_p(cce_way_groups_p),
    .num_cce_p(num_cce_p), .paddr_width_p(paddr_width_p), .addr_offset_p(addr_offset_p)
  ) dec_hash (.addr_i(dec_addr_i), .bypass_hash_i(dec_bypass_hash_i), .wg_o(dec_wg));

  bp_cce_pending_wg_hash #(
    .num_way_groups_p(num_way_groups_p), .cce_way_groups_p(cce_way_groups_p),
    .num_cce_p(num_cce_p), .paddr_width_p(paddr_width_p), .addr_offset_p(addr_offset_p)
  ) clr_hash (.addr_i(clr_addr_i), .bypass_hash_i(clr_bypass_hash_i), .wg_o(clr_wg));

  for (genvar k = 0; k < num_rd_ports_p; k++) begin : g_rd_hash
    bp_cce_pending_wg_hash #(
      .num_way_groups_p(num_way_groups_p), .cce_way_groups_p(cce_way_groups_p),
      .num_cce_p(num_cce_p), .paddr_width_p(paddr_width_p), .addr_offset_p(addr_offset_p)
    ) rd_hash (
      .addr_i(r_addr_i[k*paddr_width_p+:paddr_width_p]),
      .bypass_hash_i(r_bypass_hash_i[k]),
      .wg_o(r_wg[k])
    );
  end

  // Next-state per way group; on simultaneous errors the lowest way group is reported
  always_comb begin : next_state
    logic inc_hit, dec_hit, clr_hit;
    err_ev     = 1'b0;
    err_ev_ovf = 1'b0;
    err_ev_wg  = '0;
    inc_hit    = 1'b0;
    dec_hit    = 1'b0;
    clr_hit    = 1'b0;
    for (int g = 0; g < num_way_groups_p; g++) begin
      inc_hit  = inc_v_i && (inc_wg == lg_wg_lp'(g));
      dec_hit  = dec_v_i && (dec_wg == lg_wg_lp'(g));
      clr_hit  = clr_v_i && (clr_wg == lg_wg_lp'(g));
      cnt_n[g] = cnt_r[g];
      if (clr_hit) begin
        cnt_n[g] = '0;
      end else if (inc_hit && !dec_hit) begin
        if (sat_en_lp && (cnt_r[g] == '1)) begin
          if (!err_ev) begin
            err_ev     = 1'b1;
            err_ev_ovf = 1'b1;
            err_ev_wg  = lg_wg_lp'(g);
          end
        end else begin
          cnt_n[g] = cnt_r[g] + width_p'(1);
        end
      end else if (dec_hit && !inc_hit) begin
        if (sat_en_lp && (cnt_r[g] == '0)) begin
          if (!err_ev) begin
            err_ev     = 1'b1;
            err_ev_ovf = 1'b0;
            err_ev_wg  = lg_wg_lp'(g);
          end
        end else begin
          cnt_n[g] = cnt_r[g] - width_p'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int g = 0; g < num_way_groups_p; g++) cnt_r[g] <= '0;
    end else begin
      for (int g = 0; g < num_way_groups_p; g++) cnt_r[g] <= cnt_n[g];
    end
  end

  // Reads see this cycle's updates so the requester never observes a stale count
  always_comb begin
    count_o   = '0;
    pending_o = '0;
    for (int k = 0; k < num_rd_ports_p; k++) begin
      for (int g = 0; g < num_way_groups_p; g++) begin
        if (r_v_i[k] && (r_wg[k] == lg_wg_lp'(g))) begin
          count_o[k*width_p+:width_p] = cnt_n[g];
          pending_o[k]                = |cnt_n[g];
        end
      end
    end
  end

  always_comb begin
    any_pending_o = 1'b0;
    for (int g = 0; g < num_way_groups_p; g++) any_pending_o = any_pending_o | (|cnt_r[g]);
  end

`ifdef BP_CCE_PENDING_SATURATE_EN
  logic            err_v_r;
  bp_pending_err_s err_r;
  logic            unused_err_hi;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_v_r <= 1'b0;
      err_r   <= '0;
    end else if (err_ev && (!err_v_r || err_clr_i)) begin
      err_v_r   <= 1'b1;
      err_r.ovf <= err_ev_ovf;
      err_r.wg  <= bp_pending_wg_width_gp'(err_ev_wg);
    end else if (err_clr_i) begin
      err_v_r <= 1'b0;
    end
  end

  assign err_o         = err_v_r;
  assign err_ovf_o     = err_r.ovf;
  assign err_wg_o      = err_r.wg[lg_wg_lp-1:0];
  assign unused_err_hi = ^err_r.wg;
`else
  logic unused_err;

  assign err_o      = 1'b0;
  assign err_ovf_o  = 1'b0;
  assign err_wg_o   = '0;
  assign unused_err = ^{err_clr_i, err_ev, err_ev_ovf, err_ev_wg};
`endif

endmodule

// File: doc/bp_cce_pending_counters.md
BP_CCE_PENDING_COUNTERS -- requirements
Module: bp_cce_pending_counters

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- num_way_groups_p, none, way groups managed by this CCE.
- cce_way_groups_p, none, way groups in the whole system.
- num_cce_p, none, CCE count used for hashing.
- paddr_width_p, none, physical address width.
- addr_offset_p, none, LSB of the way-group field in the address.
- width_p, 3, counter width.
- num_rd_ports_p, 2, number of read ports.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- inc_v_i / inc_addr_i / inc_bypass_hash_i, in, 1/paddr_width_p/1, increment request.
- dec_v_i / dec_addr_i / dec_bypass_hash_i, in, 1/paddr_width_p/1, decrement request.
- clr_v_i / clr_addr_i / clr_bypass_hash_i, in, 1/paddr_width_p/1, clear-to-zero request.
- r_v_i, in, num_rd_ports_p, per-port read valid.
- r_addr_i, in, num_rd_ports_p x paddr_width_p, read addresses.
- r_bypass_hash_i, in, num_rd_ports_p, per-port hash bypass.
- pending_o, out, num_rd_ports_p, counter of the addressed way group is non-zero.
- count_o, out, num_rd_ports_p x width_p, counter value of the addressed way group.
- any_pending_o, out, 1, some registered counter is non-zero.
- err_o, out, 1, sticky saturation error.
- err_ovf_o, out, 1, the captured error was an overflow (0 = underflow).
- err_wg_o, out, log2(num_way_groups_p), way group of the first error.
- err_clr_i, in, 1, clears the error state.

Function
REQ-003 Each address SHALL map to a way group. With bypass=1 the way group is addr[0+:log2(num_way_groups_p)]. With bypass=0 it is the bsg_hash_bank index of bit-reversed addr[addr_offset_p+:log2(cce_way_groups_p)], banks = num_cce_p.
REQ-004 Counters SHALL update on the clock edge. Each counter's next value depends only on the inc, dec and clr requests that hit its way group that cycle.
REQ-005 A clr hit SHALL force the next value to 0, overriding any inc or dec to the same way group.
REQ-006 An inc and a dec hitting the same way group, with no clr, SHALL leave it unchanged and raise no error.
REQ-007 An inc alone SHALL add 1 to the counter; a dec alone SHALL subtract 1.
REQ-008 All three requests targeting different way groups SHALL all take effect in the same cycle.
REQ-009 Read ports SHALL be combinational (0-cycle latency) and SHALL return the next-state value of the addressed way group, i.e. write-to-read forwarding.
REQ-010 pending_o[k] SHALL equal (count_o[k] != 0). Both SHALL be 0 when r_v_i[k]=0.
REQ-011 Multiple read ports addressing the same way group SHALL return identical values.
REQ-012 any_pending_o SHALL be the OR over registered counters only, with no forwarding, so it appears 1 cycle after an update.
REQ-013 Error capture SHALL be:
- On an error event with err_o=0, set err_o and record err_ovf_o and err_wg_o.
- Later events while err_o=1 SHALL NOT change the captured fields.
- err_clr_i clears err_o at the next edge.
- A new error in the same cycle as err_clr_i SHALL win and be captured.

Reset
REQ-014 Asserting reset_n_i=0 SHALL asynchronously clear all counters, err_o, err_ovf_o and err_wg_o, including mid-operation.
REQ-015 During reset, any_pending_o SHALL be 0. pending_o and count_o SHALL reflect zero counters plus only the current cycle's requests.
REQ-016 The first update SHALL occur on the first clk_i rising edge after reset_n_i deasserts.

Configuration
REQ-017 Macro BP_CCE_PENDING_SATURATE_EN defined:
- inc at 2^width_p-1 SHALL hold the value and is an overflow error event.
- dec at 0 SHALL hold 0 and is an underflow error event.
REQ-018 Macro absent:
- Counters SHALL wrap modulo 2^width_p.
- err_o, err_ovf_o and err_wg_o SHALL be tied to 0; err_clr_i is ignored.

Structure
REQ-019 Shared package bp_me_pkg SHALL hold the saturation-error struct typedef {ovf, wg}. The default counter width constant SHALL live there as well.
REQ-020 Hashing SHALL be one sub-module, bp_cce_pending_wg_hash (address, bypass -> way group), instantiated 3+num_rd_ports_p times.

Verification (num_way_groups_p=8, width_p=3, bypass=1, macro defined unless noted)
REQ-021 The bench SHALL cover:
- inc wg 2 three cycles -> count_o=3, pending_o=1. any_pending_o=1 from cycle 2.
- inc wg 5 and read wg 5 in the same cycle, counter 0 -> count_o=1 that cycle (forwarding).
- inc+dec wg 4 with counter 2 -> stays 2. clr+inc wg 4 -> 0.
- 8 incs wg 1 -> holds 7, err_o=1, err_ovf_o=1, err_wg_o=1. Later dec wg 0 at 0 -> fields unchanged.
- Macro off: 8 incs wg 1 -> 0, err_o=0. Dec at 0 -> 7.
- reset_n_i low mid-stream with counters 3/7 -> all 0 and err_o=0 immediately, before the next edge.
